lsu_wb_master: RTL

- Load/store initiator on the CPU side of the Wishbone-style data bus. It is the master that drives the bus interconnect.
- Accepts one core memory request at a time (address, size/sign code, write data, direction) and issues a single pipelined-Wishbone transfer (stb/stall/ack).
- Returns read data or an error to the core.
- Rejects misaligned or illegal requests locally, without starting a bus cycle.

---
 rtl/lsu_wb_master.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/lsu_wb_master.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_wb_master
//  Brief    : Load/store initiator for a pipelined Wishbone data bus. Takes
//             one core request at a time, rejects misaligned/illegal requests
//             locally, issues a single stb/stall/ack transfer otherwise and
//             returns a one-cycle response pulse to the core.
//  Options  : LSU_TIMEOUT_EN - enables an ack timeout of TIMEOUT_CYCLES
//             cycles counted from entry into REQ.
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_wb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TO_W           = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    // core request / response
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_addr,
    input  logic        i_req_we,
    input  logic [2:0]  i_req_sel,
    input  logic [31:0] i_req_data,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_data,
    output logic        o_rsp_err,
    // Wishbone master side
    output logic        o_wb_stb,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic        o_wb_we,
    output logic [2:0]  o_wb_sel,
    input  logic [31:0] i_wb_data,
    input  logic        i_wb_ack,
    input  logic        i_wb_stall
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_stb_nxt;
    logic [31:0] w_addr_nxt;
    logic [31:0] w_wdata_nxt;
    logic        w_we_nxt;
    logic [2:0]  w_sel_nxt;
    logic        w_rsp_valid_nxt;
    logic        w_rsp_err_nxt;
    logic [31:0] w_rsp_data_nxt;

    logic        w_sel_illegal;
    logic        w_misaligned;
    logic        w_reject;
    logic        w_accepted;
    logic        w_timeout;
    logic [31:0] w_load_data;

    // Counter width must be able to hold the timeout limit.
    if (64'(TIMEOUT_CYCLES) >= (64'd1 << TO_W)) begin : g_to_width_check
        $error("lsu_wb_master: TO_W too narrow for TIMEOUT_CYCLES");
    end

    // Unused size codes, and zero-extend codes on a store, have no meaning.
    assign w_sel_illegal = (i_req_sel == 3'b011) || (i_req_sel == 3'b110) ||
                           (i_req_sel == 3'b111) || (i_req_we && i_req_sel[2]);
    // Halfword codes are 001/101, word code is 010.
    assign w_misaligned  = ((i_req_sel[1:0] == 2'b01) && i_req_addr[0]) ||
                           ((i_req_sel == 3'b010) && (i_req_addr[1:0] != 2'b00));
    assign w_reject      = w_sel_illegal || w_misaligned;
    assign w_accepted    = o_wb_stb && !i_wb_stall;
    // Stores never return bus data to the core.
    assign w_load_data   = o_wb_we ? 32'd0 : i_wb_data;

    assign o_req_ready   = (r_state == S_IDLE);

`ifdef LSU_TIMEOUT_EN
    logic [TO_W-1:0] r_to_cnt;

    // Fires on the last permitted REQ/WAIT cycle so the response lands
    // exactly TIMEOUT_CYCLES cycles after entering REQ.
    assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Cycle counter: held at zero in IDLE, counts every REQ/WAIT cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset || (r_state == S_IDLE)) begin
            r_to_cnt <= '0;
        end else if ((r_state == S_REQ) || (r_state == S_WAIT)) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        w_state_nxt     = r_state;
        w_stb_nxt       = o_wb_stb;
        w_addr_nxt      = o_wb_addr;
        w_wdata_nxt     = o_wb_data;
        w_we_nxt        = o_wb_we;
        w_sel_nxt       = o_wb_sel;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_err_nxt   = 1'b0;
        w_rsp_data_nxt  = o_rsp_data;
        case (r_state)
            S_IDLE: begin
                if (i_req_valid) begin
                    if (w_reject) begin
                        w_state_nxt     = S_RESP;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_err_nxt   = 1'b1;
                        w_rsp_data_nxt  = 32'd0;
                    end else begin
                        w_state_nxt = S_REQ;
                        w_stb_nxt   = 1'b1;
                        w_addr_nxt  = i_req_addr;
                        w_wdata_nxt = i_req_data;
                        w_we_nxt    = i_req_we;
                        w_sel_nxt   = i_req_sel;
                    end
                end
            end
            S_REQ: begin
                // An ack only counts once the strobe has been accepted.
                if (w_accepted && i_wb_ack) begin
                    w_state_nxt     = S_RESP;
                    w_stb_nxt       = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_data_nxt  = w_load_data;
                end else if (w_timeout) begin
                    w_state_nxt     = S_RESP;
                    w_stb_nxt       = 1'b0;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_data_nxt  = 32'd0;
                end else if (w_accepted) begin
                    w_state_nxt = S_WAIT;
                    w_stb_nxt   = 1'b0;
                end
            end
            S_WAIT: begin
                if (i_wb_ack) begin
                    w_state_nxt     = S_RESP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_data_nxt  = w_load_data;
                end else if (w_timeout) begin
                    w_state_nxt     = S_RESP;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_data_nxt  = 32'd0;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_stb_nxt   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight transfer.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            o_wb_stb    <= 1'b0;
            o_wb_addr   <= 32'd0;
            o_wb_data   <= 32'd0;
            o_wb_we     <= 1'b0;
            o_wb_sel    <= 3'd0;
            o_rsp_valid <= 1'b0;
            o_rsp_err   <= 1'b0;
            o_rsp_data  <= 32'd0;
        end else begin
            r_state     <= w_state_nxt;
            o_wb_stb    <= w_stb_nxt;
            o_wb_addr   <= w_addr_nxt;
            o_wb_data   <= w_wdata_nxt;
            o_wb_we     <= w_we_nxt;
            o_wb_sel    <= w_sel_nxt;
            o_rsp_valid <= w_rsp_valid_nxt;
            o_rsp_err   <= w_rsp_err_nxt;
            o_rsp_data  <= w_rsp_data_nxt;
        end
    end

endmodule
`default_nettype wire
